// File: rtl/hilo_divider.sv
// hilo_divider: sequential signed 32-bit divider feeding the HI/LO register pair.
// A start in IDLE latches operand magnitudes and signs. CALC then runs 32
// restoring shift-subtract steps, and FIX applies the result signs and writes
// HI (remainder) and LO (quotient).
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes
// on the next edge with HI=A, LO=0, div_by_zero=1. Without the macro a zero
// divisor runs the full sequence and div_by_zero stays 0.
module hilo_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [4:0]  count;
    logic [31:0] divisor_mag;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        sign_a;
    logic        sign_q;

    logic        accept;
    logic        load;
    logic        step;
    logic        finish;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic        step_ge;
    logic [31:0] step_rem;
    logic [31:0] signed_quo;
    logic [31:0] signed_rem;

`ifdef DIV_ZERO_FAST_EN
    logic        b_is_zero;
    logic        zero_div;

    assign b_is_zero = (B == 32'd0);
`endif

    // A request is taken only when idle and not in the done cycle, so a start
    // held through completion never chains into a second operation.
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    // Magnitudes are plain unsigned negation, so 0x80000000 maps to itself.
    assign abs_a = A[31] ? (32'd0 - A) : A;
    assign abs_b = B[31] ? (32'd0 - B) : B;

    // One restoring step: bring the next dividend bit (MSB of quo) into the
    // partial remainder and subtract the divisor if it fits. The 33-bit trial
    // keeps the bit that falls off the top of the 32-bit remainder.
    assign trial    = {rem, quo[31]};
    assign step_ge  = (trial >= {1'b0, divisor_mag});
    assign step_rem = trial[31:0] - divisor_mag;

    // Sign correction: quotient follows sign(A) XOR sign(B), remainder sign(A).
    assign signed_quo = sign_q ? (32'd0 - quo) : quo;
    assign signed_rem = sign_a ? (32'd0 - rem) : rem;

    // Next-state and control strobes for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    if (b_is_zero) begin
                        next_state = FIX;
                    end else begin
                        next_state = CALC;
                    end
`else
                    next_state = CALC;
`endif
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == 5'd0) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Iteration counter: 31 at load, counts down once per CALC step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 5'd0;
        end else if (load) begin
            count <= 5'd31;
        end else if (step && (count != 5'd0)) begin
            count <= count - 5'd1;
        end
    end

    // Operand capture at accept and the shift-subtract datapath during CALC.
    // The quotient register starts holding |A| and shifts dividend bits out
    // while quotient bits shift in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor_mag <= 32'd0;
            rem         <= 32'd0;
            quo         <= 32'd0;
            sign_a      <= 1'b0;
            sign_q      <= 1'b0;
        end else if (load) begin
            divisor_mag <= abs_b;
            sign_a      <= A[31];
            sign_q      <= A[31] ^ B[31];
`ifdef DIV_ZERO_FAST_EN
            if (b_is_zero) begin
                rem <= abs_a;
                quo <= 32'd0;
            end else begin
                rem <= 32'd0;
                quo <= abs_a;
            end
`else
            rem <= 32'd0;
            quo <= abs_a;
`endif
        end else if (step) begin
            rem <= step_ge ? step_rem : trial[31:0];
            quo <= {quo[30:0], step_ge};
        end
    end

`ifdef DIV_ZERO_FAST_EN
    // Remember whether the accepted divisor was zero, for reporting in FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_div <= 1'b0;
        end else if (load) begin
            zero_div <= b_is_zero;
        end
    end
`endif

    // Result registers: HI/LO change only in FIX, with a one-cycle done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI   <= 32'd0;
            LO   <= 32'd0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                HI <= signed_rem;
                LO <= signed_quo;
            end
        end
    end

`ifdef DIV_ZERO_FAST_EN
    // Zero-divisor flag, qualified by done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_by_zero <= 1'b0;
        end else if (finish) begin
            div_by_zero <= zero_div;
        end else begin
            div_by_zero <= 1'b0;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: randomized bench for hilo_divider with an arithmetic model
// and a per-cycle compare process. Honours DIV_ZERO_FAST_EN like the design.
module tb_hilo_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          done_edge;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] held_hi;
    logic [31:0] held_lo;
    int          edge_cnt;
    int          tests_run;
    int          tests_failed;

    hilo_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .HI          (HI),
        .LO          (LO),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so completion latency can be measured.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    // Reference: truncating signed division on 64-bit integers.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dbz, output int lat);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
`ifdef DIV_ZERO_FAST_EN
            lo  = 32'd0;
            hi  = a;
            dbz = 1'b1;
            lat = 1;
`else
            lo  = (sa >= 0) ? 32'hFFFFFFFF : 32'h00000001;
            hi  = a;
            dbz = 1'b0;
            lat = 33;
`endif
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            lo  = 32'(q);
            hi  = 32'(r);
            dbz = 1'b0;
            lat = 33;
        end
    endfunction

    task automatic checkModel(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] lo_lit, input logic [31:0] hi_lit);
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          lat;
        model(a, b, lo, hi, dbz, lat);
        checkOutput("model_lo", lo, lo_lit);
        checkOutput("model_hi", hi, hi_lit);
    endtask

    // Waits for an idle divider, presents one start cycle and queues the expected result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((busy || done || expq.size() != 0) && guard < 100);
        #1;
        A     = a;
        B     = b;
        start = 1'b1;
        model(a, b, e.lo, e.hi, e.dbz, lat);
        e.done_edge = edge_cnt + 1 + lat;
        expq.push_back(e);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (expq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (expq.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 100 cycles");
            expq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulseReset();
        #1;
        reset = 1'b0;
        expq.delete();
        held_hi = 32'd0;
        held_lo = 32'd0;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Compare process: checks every output on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            checkOutput("reset_busy", {31'd0, busy}, 32'd0);
            checkOutput("reset_done", {31'd0, done}, 32'd0);
            checkOutput("reset_hi", HI, 32'd0);
            checkOutput("reset_lo", LO, 32'd0);
            checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        end else if (done) begin
            checkOutput("busy_with_done", {31'd0, busy}, 32'd0);
            if (expq.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL spurious_done: got done=1, expected done=0");
            end else begin
                e = expq.pop_front();
                checkOutput("lo", LO, e.lo);
                checkOutput("hi", HI, e.hi);
                checkOutput("dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
                checkOutput("done_edge", edge_cnt, e.done_edge);
                held_hi = e.hi;
                held_lo = e.lo;
            end
        end else begin
            checkOutput("busy", {31'd0, busy}, {31'd0, expq.size() != 0});
            checkOutput("hold_hi", HI, held_hi);
            checkOutput("hold_lo", LO, held_lo);
            checkOutput("idle_dbz", {31'd0, div_by_zero}, 32'd0);
        end
    end

    initial begin
        int          guard;
        logic [31:0] ra;
        logic [31:0] rb;
        tests_run    = 0;
        tests_failed = 0;
        edge_cnt     = 0;
        held_hi      = 32'd0;
        held_lo      = 32'd0;
        reset        = 1'b0;
        start        = 1'b0;
        A            = 32'd0;
        B            = 32'd0;

        // Pin the model with hand-computed results.
        checkModel(32'd100, 32'd7, 32'd14, 32'd2);
        checkModel(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        checkModel(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        checkModel(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        checkModel(32'd20, 32'd6, 32'd3, 32'd2);
`ifdef DIV_ZERO_FAST_EN
        checkModel(32'd5, 32'd0, 32'd0, 32'd5);
`else
        checkModel(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
`endif

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        applyStimulus(32'd100, 32'd7);
        waitDone();
        applyStimulus(32'hFFFFFFF9, 32'd2);
        waitDone();
        applyStimulus(32'd7, 32'hFFFFFFFE);
        waitDone();
        applyStimulus(32'h80000000, 32'hFFFFFFFF);
        waitDone();
        applyStimulus(32'd5, 32'd0);
        waitDone();
        applyStimulus(32'hFFFFFFF3, 32'd0);
        waitDone();

        // Start while busy must not disturb the operation in flight.
        applyStimulus(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        #1;
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        waitDone();
        repeat (5) @(negedge clk);

        // Start raised in the done cycle must be ignored.
        applyStimulus(32'd1234, 32'd10);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 100);
        #1;
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        waitDone();
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts with no HI/LO update.
        applyStimulus(32'd999, 32'd4);
        repeat (9) @(negedge clk);
        pulseReset();
        repeat (40) @(negedge clk);
        applyStimulus(32'd20, 32'd6);
        waitDone();

        // Randomized operands with emphasis on sign and zero corners.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'd0 - 32'($urandom_range(1, 15));
                3: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h80000000;
            end
            applyStimulus(ra, rb);
            waitDone();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
